gesture_decoder: RTL and testbench

Converts per-frame Kinect hand coordinates into the drone command bytes `hover`, `roll` and `pitch`, plus the `on` arm flag. These are the same signals `hand_locations_display` draws and the radio/PWM back end transmits. The block sits between the Kinect hand tracker and both of those consumers. A sweep-gesture state machine in the bottom-third dead zone arms and disarms the drone.

---
 rtl/gesture_pkg.sv | 15 +
 rtl/gesture_decoder_if.sv | 9 +
 rtl/gesture_sweep_fsm.sv | 72 +++++++
 rtl/gesture_decoder.sv | 102 ++++++++++
 tb/tb_gesture_decoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gesture_pkg.sv
// gesture_pkg: shared sweep states, neutral command value, zone bounds, default geometry and output IIR helper
package gesture_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK_R, ST_TRACK_L, ST_LOCKOUT} gesture_state_t;
    localparam logic [7:0]  NEUTRAL = 8'd128;
    localparam logic [15:0] ZONE_B1 = 16'd130;
    localparam logic [15:0] ZONE_B2 = 16'd260;
    localparam logic [15:0] ZONE_B3 = 16'd390;
    localparam logic [15:0] ZONE_B4 = 16'd520;
    localparam int DEF_DEAD_Y = 341;
    localparam int DEF_MIN_Z  = 800;
    localparam int DEF_MAX_Z  = 1050;
    function automatic logic [7:0] iir(input logic [7:0] a, input logic [7:0] b);
        return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
    endfunction
endpackage

// File: rtl/gesture_decoder_if.sv
// gesture_decoder_if: per-frame hand coordinates in, drone command bytes and arm flag out
interface gesture_decoder_if;
    logic        frame_valid;
    logic [15:0] x1, y1, z1, x2, y2, z2;
    logic [7:0]  hover, roll, pitch;
    logic        on, cmd_valid;
    modport master (output frame_valid, x1, y1, z1, x2, y2, z2, input hover, roll, pitch, on, cmd_valid);
    modport slave  (input frame_valid, x1, y1, z1, x2, y2, z2, output hover, roll, pitch, on, cmd_valid);
endinterface

// File: rtl/gesture_sweep_fsm.sv
// gesture_sweep_fsm: dead-zone sweep across five x zones arms (left to right) or disarms (right to left)
module gesture_sweep_fsm
    import gesture_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_strobe,
    input  logic [2:0]     i_zone,
    input  logic           i_dz,
    output logic           o_on,
    output gesture_state_t o_state
);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    gesture_state_t r_state, w_state;
    logic [2:0]     r_prog, w_prog, w_step, w_goal;
    logic [TW-1:0]  r_tmo, w_tmo, w_tmo_inc;
    logic           r_on, w_on;

    assign w_step    = r_state == ST_TRACK_R ? r_prog + 3'd1 : r_prog - 3'd1;
    assign w_goal    = r_state == ST_TRACK_R ? 3'd4 : 3'd0;
    assign w_tmo_inc = r_tmo + TW'(1);
    assign o_on      = r_on;
    assign o_state   = r_state;

    always_comb begin
        w_state = r_state;
        w_prog  = r_prog;
        w_tmo   = r_tmo;
        w_on    = r_on;
        if (i_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    w_tmo = '0;
                    if (i_dz && (i_zone == 3'd0 || i_zone == 3'd4)) begin
                        w_state = i_zone == 3'd0 ? ST_TRACK_R : ST_TRACK_L;
                        w_prog  = i_zone;
                    end
                end
                ST_TRACK_R, ST_TRACK_L: begin
                    if (i_dz && i_zone == w_step) begin
                        w_prog = w_step;
                        w_tmo  = '0;
                        if (w_step == w_goal) begin
                            w_on    = r_state == ST_TRACK_R;
                            w_state = ST_LOCKOUT;
                        end
                    end else if (i_dz && i_zone == r_prog && w_tmo_inc != TW'(TIMEOUT_FRAMES))
                        w_tmo = w_tmo_inc;
                    else
                        w_state = ST_IDLE;
                end
                default: w_state = i_dz ? ST_LOCKOUT : ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prog  <= '0;
            r_tmo   <= '0;
            r_on    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_prog  <= w_prog;
            r_tmo   <= w_tmo;
            r_on    <= w_on;
        end
    end
endmodule

// File: rtl/gesture_decoder.sv
// gesture_decoder: Kinect hands to hover/roll/pitch/on in two stages; GESTURE_DECODER_SMOOTH_EN adds a 2-tap output IIR
module gesture_decoder
    import gesture_pkg::*;
#(
    parameter int DEAD_Y         = DEF_DEAD_Y,
    parameter int ROLL_CENTER    = 487,
    parameter int MIN_Z          = DEF_MIN_Z,
    parameter int MAX_Z          = DEF_MAX_Z,
    parameter int TIMEOUT_FRAMES = 15
) (
    input logic              vclock,
    input logic              reset_n,
    gesture_decoder_if.slave bus
);
    gesture_state_t     w_state;
    logic               w_dz_l, w_dz_r, w_sweep_dz, w_on, w_unused;
    logic [2:0]         w_zone;
    logic signed [16:0] w_dy, w_dx, w_zlo, w_zhi, w_plo, w_phi;
    logic signed [19:0] w_h4, w_r4;
    logic [7:0]         w_h1, w_r1, w_p1, w_hraw, w_rraw, w_praw, w_hover, w_roll, w_pitch;
    logic               r_v1, r_v2, r_on;
    logic [7:0]         r_hover1, r_roll1, r_pitch1, r_hover, r_roll, r_pitch;

    assign w_unused   = ^{bus.x1, w_state};
    assign w_dz_l     = bus.z1 == '0 || bus.y1 >= 16'(DEAD_Y);
    assign w_dz_r     = bus.z2 == '0 || bus.y2 >= 16'(DEAD_Y);
    assign w_sweep_dz = bus.z2 != '0 && bus.y2 >= 16'(DEAD_Y);
    assign w_zone     = bus.x2 < ZONE_B1 ? 3'd0 : bus.x2 < ZONE_B2 ? 3'd1 :
                        bus.x2 < ZONE_B3 ? 3'd2 : bus.x2 < ZONE_B4 ? 3'd3 : 3'd4;
    // 17-bit signed differences keep inputs above 0x7FFF on the saturating side
    assign w_dy  = 17'(DEAD_Y) - {1'b0, bus.y1};
    assign w_dx  = {1'b0, bus.x2} - 17'(ROLL_CENTER);
    assign w_zlo = 17'(MIN_Z) - {1'b0, bus.z2};
    assign w_zhi = {1'b0, bus.z2} - 17'(MAX_Z);
    assign w_plo = w_zlo >>> 2;
    assign w_phi = w_zhi >>> 2;
    assign w_h4  = (20'(w_dy) * 20'sd3) >>> 2;
    assign w_r4  = (20'(w_dx) * 20'sd3) >>> 2;
    assign w_h1  = w_dz_l ? 8'd0 : w_h4 > 20'sd255 ? 8'd255 : w_h4[7:0];
    assign w_r1  = w_dz_r ? NEUTRAL : w_r4 > 20'sd127 ? 8'd255 : w_r4 < -20'sd127 ? 8'd1 : w_r4[7:0] + NEUTRAL;
    assign w_p1  = w_dz_r ? NEUTRAL :
                   w_zlo > 17'sd0 ? NEUTRAL + (w_plo > 17'sd127 ? 8'd127 : w_plo[7:0]) :
                   !w_zhi[16]     ? NEUTRAL - (w_phi > 17'sd127 ? 8'd127 : w_phi[7:0]) : NEUTRAL;

    gesture_sweep_fsm #(.TIMEOUT_FRAMES(TIMEOUT_FRAMES)) u_fsm (
        .clk      (vclock),
        .rst_n    (reset_n),
        .i_strobe (bus.frame_valid),
        .i_zone   (w_zone),
        .i_dz     (w_sweep_dz),
        .o_on     (w_on),
        .o_state  (w_state)
    );

    // the FSM has already absorbed the stage-1 frame, so w_on is that frame's resulting arm state
    assign w_hraw = w_on ? r_hover1 : 8'd0;
    assign w_rraw = w_on ? r_roll1 : NEUTRAL;
    assign w_praw = w_on ? r_pitch1 : NEUTRAL;
`ifdef GESTURE_DECODER_SMOOTH_EN
    assign w_hover = r_on && !w_on ? 8'd0 : iir(r_hover, w_hraw);
    assign w_roll  = iir(r_roll, w_rraw);
    assign w_pitch = iir(r_pitch, w_praw);
`else
    assign w_hover = w_hraw;
    assign w_roll  = w_rraw;
    assign w_pitch = w_praw;
`endif

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_on     <= 1'b0;
            r_hover1 <= 8'd0;
            r_roll1  <= NEUTRAL;
            r_pitch1 <= NEUTRAL;
            r_hover  <= 8'd0;
            r_roll   <= NEUTRAL;
            r_pitch  <= NEUTRAL;
        end else begin
            r_v1 <= bus.frame_valid;
            r_v2 <= r_v1;
            if (bus.frame_valid) begin
                r_hover1 <= w_h1;
                r_roll1  <= w_r1;
                r_pitch1 <= w_p1;
            end
            if (r_v1) begin
                r_hover <= w_hover;
                r_roll  <= w_roll;
                r_pitch <= w_pitch;
                r_on    <= w_on;
            end
        end
    end

    assign bus.hover     = r_hover;
    assign bus.roll      = r_roll;
    assign bus.pitch     = r_pitch;
    assign bus.on        = r_on;
    assign bus.cmd_valid = r_v2;
endmodule

// File: tb/tb_gesture_decoder.sv
// tb_gesture_decoder: randomized frames checked every cycle against a behavioural command/sweep model
module tb_gesture_decoder;
    import gesture_pkg::*;
    localparam int DEAD_Y = 341, ROLL_CENTER = 487, MIN_Z = 800, MAX_Z = 1050, TIMEOUT_FRAMES = 15;

    typedef struct {int due; int h; int r; int p; int o;} exp_t;

    logic vclock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0, checks = 0, fails = 0, n_cmd = 0;
    exp_t q[$];
    exp_t hold, m_prev;
    int   m_mode = 0, m_dir = 1, m_pos = 0, m_stall = 0, m_on = 0;
    int   sweep_xs[5] = '{50, 180, 300, 450, 600};

    gesture_decoder_if bus ();

    gesture_decoder #(
        .DEAD_Y(DEAD_Y), .ROLL_CENTER(ROLL_CENTER), .MIN_Z(MIN_Z), .MAX_Z(MAX_Z), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) dut (
        .vclock  (vclock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vclock = ~vclock;
    always @(posedge vclock) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int f_zone(input int x);
        return x < 130 ? 0 : x < 260 ? 1 : x < 390 ? 2 : x < 520 ? 3 : 4;
    endfunction

    function automatic int f_hover(input int y1, input int z1, input int on);
        int v;
        if (on == 0 || z1 == 0 || y1 >= DEAD_Y) return 0;
        v = (DEAD_Y - y1) * 3 / 4;
        return v > 255 ? 255 : v;
    endfunction

    function automatic int f_roll(input int x2, input int y2, input int z2, input int on);
        int t;
        if (on == 0 || z2 == 0 || y2 >= DEAD_Y) return 128;
        t = ((x2 - ROLL_CENTER) * 3) >>> 2;
        return 128 + (t > 127 ? 127 : t < -127 ? -127 : t);
    endfunction

    function automatic int f_pitch(input int y2, input int z2, input int on);
        int t;
        if (on == 0 || z2 == 0 || y2 >= DEAD_Y) return 128;
        if (z2 < MIN_Z) begin
            t = (MIN_Z - z2) / 4;
            return 128 + (t > 127 ? 127 : t);
        end
        if (z2 >= MAX_Z) begin
            t = (z2 - MAX_Z) / 4;
            return 128 - (t > 127 ? 127 : t);
        end
        return 128;
    endfunction

    // sweep as a walk of position m_pos in direction m_dir; mode 0 waiting, 1 sweeping, 2 locked out
    function automatic void sweep_step(input int x2, input int y2, input int z2);
        int  z = f_zone(x2);
        bit  dz = z2 != 0 && y2 >= DEAD_Y;
        if (m_mode == 2) begin
            if (!dz) m_mode = 0;
        end else if (m_mode == 0) begin
            if (dz && (z == 0 || z == 4)) begin
                m_mode = 1; m_dir = z == 0 ? 1 : -1; m_pos = z; m_stall = 0;
            end
        end else if (dz && z == m_pos + m_dir) begin
            m_pos = z; m_stall = 0;
            if (z == 0 || z == 4) begin m_on = m_dir > 0 ? 1 : 0; m_mode = 2; end
        end else if (dz && z == m_pos && m_stall + 1 < TIMEOUT_FRAMES)
            m_stall++;
        else
            m_mode = 0;
    endfunction

    task automatic send(input int ax1, input int ay1, input int az1, input int ax2, input int ay2, input int az2);
        exp_t e;
        @(posedge vclock); #1;
        bus.frame_valid = 1'b1;
        bus.x1 = 16'(ax1); bus.y1 = 16'(ay1); bus.z1 = 16'(az1);
        bus.x2 = 16'(ax2); bus.y2 = 16'(ay2); bus.z2 = 16'(az2);
        sweep_step(ax2, ay2, az2);
        e.h = f_hover(ay1, az1, m_on);
        e.r = f_roll(ax2, ay2, az2, m_on);
        e.p = f_pitch(ay2, az2, m_on);
        e.o = m_on;
`ifdef GESTURE_DECODER_SMOOTH_EN
        e.h = (m_prev.o == 1 && m_on == 0) ? 0 : (m_prev.h + e.h + 1) / 2;
        e.r = (m_prev.r + e.r + 1) / 2;
        e.p = (m_prev.p + e.p + 1) / 2;
`endif
        e.due = cyc + 2;
        m_prev = e;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge vclock); #1;
            bus.frame_valid = 1'b0;
        end
    endtask

    task automatic sweep(input bit right, input int y2);
        for (int i = 0; i < 5; i++) send(0, 100, 900, sweep_xs[right ? i : 4 - i], y2, 900);
    endtask

    task automatic check_cycle();
        exp_t e;
        bit   due = q.size() != 0 && q[0].due == cyc;
        chk("cmd_valid", int'(bus.cmd_valid), int'(due));
        if (bus.cmd_valid) n_cmd++;
        e = hold;
        if (due) begin
            e = q.pop_front();
            hold = e;
        end
        chk("hover", int'(bus.hover), e.h);
        chk("roll", int'(bus.roll), e.r);
        chk("pitch", int'(bus.pitch), e.p);
        chk("on", int'(bus.on), e.o);
    endtask

    always @(negedge vclock) if (reset_n) check_cycle();

    task automatic check_state(input string n, input gesture_state_t e);
        idle(3);
        @(negedge vclock);
        chk(n, int'(dut.u_fsm.o_state), int'(e));
    endtask

    task automatic check_out(input string n, input int h, input int r, input int p, input int o);
        idle(3);
        @(negedge vclock);
        chk({n, "_hover"}, int'(bus.hover), h);
        chk({n, "_roll"}, int'(bus.roll), r);
        chk({n, "_pitch"}, int'(bus.pitch), p);
        chk({n, "_on"}, int'(bus.on), o);
    endtask

    task automatic do_reset();
        @(posedge vclock); #1;
        reset_n = 1'b0;
        bus.frame_valid = 1'b0;
        q.delete();
        m_mode = 0; m_pos = 0; m_stall = 0; m_on = 0;
        m_prev = '{0, 0, 128, 128, 0};
        hold = m_prev;
        repeat (2) @(posedge vclock);
        @(negedge vclock);
        chk("rst_hover", int'(bus.hover), 0);
        chk("rst_roll", int'(bus.roll), 128);
        chk("rst_pitch", int'(bus.pitch), 128);
        chk("rst_on", int'(bus.on), 0);
        chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("rst_state", int'(dut.u_fsm.o_state), int'(ST_IDLE));
        @(posedge vclock); #1;
        reset_n = 1'b1;
    endtask

    function automatic int rnd_coord(input int lo, input int hi, input bit zero_ok);
        if (zero_ok && $urandom_range(0, 5) == 0) return 0;
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 65535));
        return int'($urandom_range(lo, hi));
    endfunction

    initial begin
        int n0;
        bus.frame_valid = 1'b0;
        bus.x1 = '0; bus.y1 = '0; bus.z1 = '0; bus.x2 = '0; bus.y2 = '0; bus.z2 = '0;

        chk("pin_hover", f_hover(0, 900, 1), 255);
        chk("pin_roll", f_roll(649, 200, 500, 1), 249);
        chk("pin_roll_low", f_roll(0, 200, 900, 1), 1);
        chk("pin_roll_m1", f_roll(486, 200, 900, 1), 127);
        chk("pin_pitch", f_pitch(200, 500, 1), 203);
        chk("pin_pitch_far", f_pitch(200, 2000, 1), 1);
        chk("pin_zone_hi", f_zone(520), 4);
        chk("pin_zone_lo", f_zone(129), 0);

        do_reset();
        idle(5);

        sweep(1'b1, 400);
        check_out("arm", 180, 128, 128, 1);
        check_state("arm_lockout", ST_LOCKOUT);
        send(0, 100, 900, 300, 200, 900);
        check_state("arm_leave", ST_IDLE);

        send(0, 0, 900, 649, 200, 500);
        check_out("map", 255, 249, 203, 1);

        for (int i = 0; i < 3; i++) send(0, 100, 900, sweep_xs[i], 400, 900);
        repeat (16) send(0, 100, 900, 300, 400, 900);
        check_state("timeout_idle", ST_IDLE);
        chk("timeout_on", int'(bus.on), 1);
        send(0, 100, 900, 50, 400, 900);
        send(0, 100, 900, 180, 400, 900);
        send(0, 100, 900, 300, 400, 900);
        send(0, 100, 900, 600, 400, 900);
        check_state("wrong_order_idle", ST_IDLE);

        sweep(1'b0, 400);
        check_state("disarm_lockout", ST_LOCKOUT);
        send(0, 100, 900, 50, 400, 900);
        check_out("disarm", 0, 128, 128, 0);
        send(0, 100, 900, 300, 200, 900);

        sweep(1'b1, 400);
        send(0, 100, 900, 300, 200, 900);
        send(0, 100, 900, 50, 400, 0);
        check_out("lost_hand", 180, 128, 128, 1);
        check_state("lost_hand_idle", ST_IDLE);

        n0 = n_cmd;
        for (int i = 0; i < 4; i++)
            send(0, rnd_coord(0, 340, 0), 900, rnd_coord(0, 700, 0), rnd_coord(0, 340, 0), rnd_coord(300, 1500, 0));
        idle(4);
        chk("b2b_pulses", n_cmd - n0, 4);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sweep($urandom_range(0, 1) == 1, int'($urandom_range(DEAD_Y, 500)));
                if ($urandom_range(0, 1) == 1) send(0, 100, 900, 300, 100, 900);
            end else
                send(rnd_coord(0, 700, 0), rnd_coord(0, 500, 0), rnd_coord(300, 1500, 1),
                     rnd_coord(0, 700, 0), rnd_coord(0, 500, 0), rnd_coord(300, 1500, 1));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        send(0, 100, 900, 300, 200, 900);
        sweep(1'b1, 400);
        send(0, 100, 900, 300, 200, 900);
        send(0, 100, 900, 50, 400, 900);
        send(0, 100, 900, 180, 400, 900);
        idle(3);
        chk("pre_reset_on", int'(bus.on), 1);
        do_reset();
        check_out("post_reset", 0, 128, 128, 0);

        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
